// File: rtl/mispred_recovery_ctrl.sv
// ---------------------------------------------------------------------------
// mispred_recovery_ctrl
//
// Sequences pipeline recovery after the branch selector reports a mispredict
// or a full flush. The front end is stalled and the mispredict flush is held
// until the ROB has drained. The rename map is then restored in fixed-width
// chunks, and the pipeline is released for one cycle before returning to idle.
// A full flush skips the rename restore.
//
// Parameters:
//   NUM_ARCH_REGS  architectural registers walked by the rename-map restore
//   RESTORE_WIDTH  registers restored per cycle (must divide NUM_ARCH_REGS)
//   DRAIN_STABLE   consecutive cycles of curSqN==nextSqN needed to leave DRAIN
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   IN_branch_taken     selected branch/flush valid this cycle
//   IN_branch_sqN       sequence number of the selected branch
//   IN_branch_flush     full flush, so the rename restore is skipped
//   IN_ROB_curSqN       ROB commit pointer
//   IN_RN_nextSqN       rename next sequence number
//   OUT_mispredFlush    suppress ops younger than OUT_flushSqN
//   OUT_flushSqN        captured sequence number (held while idle)
//   OUT_stallFE         front-end/rename stall
//   OUT_restoreValid    rename restore chunk valid
//   OUT_restoreIdx      rename restore chunk index
//   OUT_busy            controller not idle
//
// Optional build macro MISPRED_RECOVERY_STATS_EN adds two saturating 32-bit
// counters:
//   OUT_statMispredCnt     captures, including recaptures
//   OUT_statRecoveryCycles cycles with OUT_busy high
// ---------------------------------------------------------------------------
module mispred_recovery_ctrl #(
  parameter int NUM_ARCH_REGS = 32,
  parameter int RESTORE_WIDTH = 4,
  parameter int DRAIN_STABLE  = 2,
  localparam int NUM_CHUNKS   = NUM_ARCH_REGS / RESTORE_WIDTH,
  localparam int IDX_W        = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             IN_branch_taken,
  input  logic [5:0]       IN_branch_sqN,
  input  logic             IN_branch_flush,
  input  logic [5:0]       IN_ROB_curSqN,
  input  logic [5:0]       IN_RN_nextSqN,
  output logic             OUT_mispredFlush,
  output logic [5:0]       OUT_flushSqN,
  output logic             OUT_stallFE,
  output logic             OUT_restoreValid,
  output logic [IDX_W-1:0] OUT_restoreIdx,
  output logic             OUT_busy
`ifdef MISPRED_RECOVERY_STATS_EN
  ,
  output logic [31:0]      OUT_statMispredCnt,
  output logic [31:0]      OUT_statRecoveryCycles
`endif
);

  localparam int DCNT_W = (DRAIN_STABLE > 1) ? $clog2(DRAIN_STABLE) : 1;
  localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(DRAIN_STABLE - 1);
  localparam logic [IDX_W-1:0]  CHUNK_LAST = IDX_W'(NUM_CHUNKS - 1);

  typedef enum logic [1:0] {IDLE, DRAIN, RESTORE, RELEASE} state_t;

  state_t            state;
  logic              cap_flush;
  logic [DCNT_W-1:0] drain_cnt;
  logic [5:0]        age_diff;
  logic              older;
  logic              capture;
  logic              drain_eq;

  // Sequence numbers wrap at 64, so age is the sign of the 6-bit difference.
  assign age_diff = IN_branch_sqN - OUT_flushSqN;
  assign older    = age_diff[5];
  assign drain_eq = (IN_ROB_curSqN == IN_RN_nextSqN);

  // RELEASE accepts any new branch just like IDLE, because the previous
  // recovery is already complete; elsewhere only an older branch wins.
  assign capture = IN_branch_taken &&
                   ((state == IDLE) || (state == RELEASE) || older);

  // OUT_restoreIdx doubles as the chunk counter. It is kept at 0 outside
  // RESTORE so it always starts a walk from the first chunk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      cap_flush        <= 1'b0;
      drain_cnt        <= '0;
      OUT_mispredFlush <= 1'b0;
      OUT_flushSqN     <= 6'd0;
      OUT_stallFE      <= 1'b0;
      OUT_restoreValid <= 1'b0;
      OUT_restoreIdx   <= '0;
      OUT_busy         <= 1'b0;
    end else if (capture) begin
      state            <= DRAIN;
      cap_flush        <= IN_branch_flush;
      drain_cnt        <= '0;
      OUT_flushSqN     <= IN_branch_sqN;
      OUT_mispredFlush <= 1'b1;
      OUT_stallFE      <= 1'b1;
      OUT_restoreValid <= 1'b0;
      OUT_restoreIdx   <= '0;
      OUT_busy         <= 1'b1;
    end else begin
      case (state)
        DRAIN: begin
          if (!drain_eq) begin
            drain_cnt <= '0;
          end else if (drain_cnt == DRAIN_LAST) begin
            drain_cnt <= '0;
            if (cap_flush) begin
              state            <= RELEASE;
              OUT_mispredFlush <= 1'b0;
              OUT_stallFE      <= 1'b0;
            end else begin
              state            <= RESTORE;
              OUT_restoreValid <= 1'b1;
              OUT_restoreIdx   <= '0;
            end
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        RESTORE: begin
          if (OUT_restoreIdx == CHUNK_LAST) begin
            state            <= RELEASE;
            OUT_restoreValid <= 1'b0;
            OUT_restoreIdx   <= '0;
            OUT_mispredFlush <= 1'b0;
            OUT_stallFE      <= 1'b0;
          end else begin
            OUT_restoreIdx <= OUT_restoreIdx + 1'b1;
          end
        end
        RELEASE: begin
          state    <= IDLE;
          OUT_busy <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef MISPRED_RECOVERY_STATS_EN
  // Both statistics counters saturate rather than wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      OUT_statMispredCnt     <= 32'd0;
      OUT_statRecoveryCycles <= 32'd0;
    end else begin
      if (capture && (OUT_statMispredCnt != 32'hFFFF_FFFF)) begin
        OUT_statMispredCnt <= OUT_statMispredCnt + 32'd1;
      end
      if (OUT_busy && (OUT_statRecoveryCycles != 32'hFFFF_FFFF)) begin
        OUT_statRecoveryCycles <= OUT_statRecoveryCycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mispred_recovery_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mispred_recovery_ctrl
//
// Self-checking bench for mispred_recovery_ctrl at default parameters.
// A behavioural model of the recovery sequence predicts every output and is
// compared on each falling edge. Directed scenarios pin exact values, and a
// randomized phase then exercises the design with arbitrary branches.
// ---------------------------------------------------------------------------
module tb_mispred_recovery_ctrl;

  localparam int NUM_CHUNKS   = 8;
  localparam int DRAIN_STABLE = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       IN_branch_taken = 1'b0;
  logic [5:0] IN_branch_sqN = 6'd0;
  logic       IN_branch_flush = 1'b0;
  logic [5:0] IN_ROB_curSqN = 6'd0;
  logic [5:0] IN_RN_nextSqN = 6'd1;
  logic       OUT_mispredFlush;
  logic [5:0] OUT_flushSqN;
  logic       OUT_stallFE;
  logic       OUT_restoreValid;
  logic [2:0] OUT_restoreIdx;
  logic       OUT_busy;
`ifdef MISPRED_RECOVERY_STATS_EN
  logic [31:0] OUT_statMispredCnt;
  logic [31:0] OUT_statRecoveryCycles;
`endif

  int checks = 0;
  int errors = 0;

  mispred_recovery_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .IN_branch_taken  (IN_branch_taken),
    .IN_branch_sqN    (IN_branch_sqN),
    .IN_branch_flush  (IN_branch_flush),
    .IN_ROB_curSqN    (IN_ROB_curSqN),
    .IN_RN_nextSqN    (IN_RN_nextSqN),
    .OUT_mispredFlush (OUT_mispredFlush),
    .OUT_flushSqN     (OUT_flushSqN),
    .OUT_stallFE      (OUT_stallFE),
    .OUT_restoreValid (OUT_restoreValid),
    .OUT_restoreIdx   (OUT_restoreIdx),
    .OUT_busy         (OUT_busy)
`ifdef MISPRED_RECOVERY_STATS_EN
    ,
    .OUT_statMispredCnt     (OUT_statMispredCnt),
    .OUT_statRecoveryCycles (OUT_statRecoveryCycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Behavioural model: the recovery is described by what still remains to be
  // done. This covers waiting for a stable drain, the restore chunks still
  // to issue, and a pending release cycle.
  bit         mDrain;
  bit         mRelease;
  int         mEqRun;
  int         mRestore;
  logic [5:0] mCapSqn;
  bit         mCapFlush;
  longint     mCapCount;
  longint     mBusyCycles;
  bit         mIdle;
  bit         mOlder;
  bit         mEq;
  int         mDist;

  function automatic bit modelBusy();
    return mDrain || (mRestore >= 0) || mRelease;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mDrain      = 0;
      mRelease    = 0;
      mEqRun      = 0;
      mRestore    = -1;
      mCapSqn     = 6'd0;
      mCapFlush   = 0;
      mCapCount   = 0;
      mBusyCycles = 0;
    end else begin
      mIdle = !modelBusy();
      mDist = (int'(IN_branch_sqN) - int'(mCapSqn) + 64) % 64;
      mOlder = (mDist >= 32);
      mEq = (IN_ROB_curSqN == IN_RN_nextSqN);
      if (modelBusy()) mBusyCycles++;
      if (IN_branch_taken && (mIdle || mRelease || mOlder)) begin
        mCapSqn   = IN_branch_sqN;
        mCapFlush = IN_branch_flush;
        mDrain    = 1;
        mEqRun    = 0;
        mRestore  = -1;
        mRelease  = 0;
        mCapCount++;
      end else if (mDrain) begin
        if (mEq) begin
          mEqRun++;
          if (mEqRun == DRAIN_STABLE) begin
            mDrain = 0;
            mEqRun = 0;
            if (mCapFlush) mRelease = 1;
            else mRestore = 0;
          end
        end else begin
          mEqRun = 0;
        end
      end else if (mRestore >= 0) begin
        if (mRestore == NUM_CHUNKS - 1) begin
          mRestore = -1;
          mRelease = 1;
        end else begin
          mRestore++;
        end
      end else if (mRelease) begin
        mRelease = 0;
      end
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    checkOutput("mispredFlush", OUT_mispredFlush, mDrain || (mRestore >= 0));
    checkOutput("stallFE", OUT_stallFE, mDrain || (mRestore >= 0));
    checkOutput("restoreValid", OUT_restoreValid, mRestore >= 0);
    checkOutput("restoreIdx", OUT_restoreIdx, (mRestore >= 0) ? mRestore : 0);
    checkOutput("busy", OUT_busy, modelBusy());
    checkOutput("flushSqN", OUT_flushSqN, mCapSqn);
`ifdef MISPRED_RECOVERY_STATS_EN
    checkOutput("statMispredCnt", OUT_statMispredCnt, mCapCount[31:0]);
    checkOutput("statRecoveryCycles", OUT_statRecoveryCycles, mBusyCycles[31:0]);
`endif
  end

  // Drive one cycle of inputs and return at the next falling edge, when the
  // outputs reflect the rising edge that sampled them.
  task automatic applyStimulus(input bit taken, input logic [5:0] sqn,
                               input bit flush, input bit eq);
    IN_branch_taken = taken;
    IN_branch_sqN   = sqn;
    IN_branch_flush = flush;
    IN_ROB_curSqN   = 6'd7;
    IN_RN_nextSqN   = eq ? 6'd7 : 6'd8;
    @(negedge clk);
  endtask

  task automatic settle();
    int n;
    n = 0;
    applyStimulus(0, 6'd0, 0, 1);
    while (OUT_busy && n < 60) begin
      applyStimulus(0, 6'd0, 0, 1);
      n++;
    end
    checkOutput("settleIdle", OUT_busy, 1'b0);
  endtask

  initial begin
    logic [5:0] cur;
    $display("[TB] start");
    @(negedge clk);
    @(negedge clk);
    checkOutput("resetBusy", OUT_busy, 1'b0);
    checkOutput("resetFlush", OUT_mispredFlush, 1'b0);
    rst_n = 1'b1;
    applyStimulus(0, 6'd0, 0, 0);

    // Basic mispredict, sqN 10. The drain becomes stable from the second cycle.
    applyStimulus(1, 6'd10, 0, 0);
    checkOutput("basicFlushSqN", OUT_flushSqN, 6'd10);
    checkOutput("basicMispred", OUT_mispredFlush, 1'b1);
    checkOutput("basicStall", OUT_stallFE, 1'b1);
    checkOutput("basicBusy", OUT_busy, 1'b1);
    applyStimulus(0, 6'd0, 0, 1);
    checkOutput("basicDrainNoRestore", OUT_restoreValid, 1'b0);
    applyStimulus(0, 6'd0, 0, 1);
    checkOutput("basicRestore0", OUT_restoreValid, 1'b1);
    checkOutput("basicIdx0", OUT_restoreIdx, 3'd0);
    for (int i = 1; i < NUM_CHUNKS; i++) begin
      applyStimulus(0, 6'd0, 0, 1);
      checkOutput("basicIdxSeq", OUT_restoreIdx, i);
    end
    applyStimulus(0, 6'd0, 0, 1);
    checkOutput("basicReleaseBusy", OUT_busy, 1'b1);
    checkOutput("basicReleaseMispred", OUT_mispredFlush, 1'b0);
    checkOutput("basicReleaseValid", OUT_restoreValid, 1'b0);
    applyStimulus(0, 6'd0, 0, 1);
    checkOutput("basicIdle", OUT_busy, 1'b0);
    checkOutput("basicHoldSqN", OUT_flushSqN, 6'd10);

    // Full flush, sqN 20. The restore is skipped; drain equality on the
    // capture cycle does not count toward stability.
    applyStimulus(1, 6'd20, 1, 1);
    applyStimulus(0, 6'd0, 0, 1);
    checkOutput("flushStillDrain", OUT_mispredFlush, 1'b1);
    applyStimulus(0, 6'd0, 0, 1);
    checkOutput("flushRelease", OUT_mispredFlush, 1'b0);
    checkOutput("flushReleaseBusy", OUT_busy, 1'b1);
    checkOutput("flushNoRestore", OUT_restoreValid, 1'b0);
    applyStimulus(0, 6'd0, 0, 1);
    checkOutput("flushIdle", OUT_busy, 1'b0);

    // Older override in the middle of a restore.
    applyStimulus(1, 6'd12, 0, 1);
    applyStimulus(0, 6'd0, 0, 1);
    applyStimulus(0, 6'd0, 0, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 6'd0, 0, 1);
    checkOutput("ovrIdx3", OUT_restoreIdx, 3'd3);
    checkOutput("ovrModelIdx3", mRestore, 3);
    applyStimulus(1, 6'd9, 0, 1);
    checkOutput("ovrSqN9", OUT_flushSqN, 6'd9);
    checkOutput("ovrValidCleared", OUT_restoreValid, 1'b0);
    checkOutput("ovrIdxCleared", OUT_restoreIdx, 3'd0);
    applyStimulus(1, 6'd15, 0, 1);
    checkOutput("ovrYoungerIgnored", OUT_flushSqN, 6'd9);
    applyStimulus(0, 6'd0, 0, 1);
    checkOutput("ovrRestart", OUT_restoreValid, 1'b1);
    checkOutput("ovrRestartIdx", OUT_restoreIdx, 3'd0);
    settle();

    // Wrap-around: 1 is younger than 62, while 62 is older than 1.
    applyStimulus(1, 6'd62, 0, 0);
    applyStimulus(1, 6'd1, 0, 0);
    checkOutput("wrapIgnore", OUT_flushSqN, 6'd62);
    settle();
    applyStimulus(1, 6'd1, 0, 0);
    applyStimulus(1, 6'd62, 0, 0);
    checkOutput("wrapRecapture", OUT_flushSqN, 6'd62);
    settle();

    // Drain glitch: the equality run is true, then false, then true twice.
    applyStimulus(1, 6'd30, 0, 0);
    applyStimulus(0, 6'd0, 0, 1);
    applyStimulus(0, 6'd0, 0, 0);
    applyStimulus(0, 6'd0, 0, 1);
    checkOutput("glitchNotYet", OUT_restoreValid, 1'b0);
    applyStimulus(0, 6'd0, 0, 1);
    checkOutput("glitchRestore", OUT_restoreValid, 1'b1);
    settle();

    // Asynchronous reset mid-restore at index 3, applied without a clock edge.
    applyStimulus(1, 6'd5, 0, 1);
    applyStimulus(0, 6'd0, 0, 1);
    applyStimulus(0, 6'd0, 0, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 6'd0, 0, 1);
    checkOutput("rstPreIdx", OUT_restoreIdx, 3'd3);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rstAsyncBusy", OUT_busy, 1'b0);
    checkOutput("rstAsyncValid", OUT_restoreValid, 1'b0);
    checkOutput("rstAsyncIdx", OUT_restoreIdx, 3'd0);
    checkOutput("rstAsyncMispred", OUT_mispredFlush, 1'b0);
    checkOutput("rstAsyncStall", OUT_stallFE, 1'b0);
    checkOutput("rstAsyncSqN", OUT_flushSqN, 6'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 6'd0, 0, 1);
    checkOutput("rstIdleAfter", OUT_busy, 1'b0);

    // Randomized phase, checked every cycle by the model comparison.
    for (int c = 0; c < 3000; c++) begin
      IN_branch_taken = ($urandom_range(0, 7) == 0);
      IN_branch_sqN   = 6'($urandom_range(0, 63));
      IN_branch_flush = ($urandom_range(0, 3) == 0);
      cur             = 6'($urandom_range(0, 63));
      IN_ROB_curSqN   = cur;
      IN_RN_nextSqN   = ($urandom_range(0, 3) != 0) ? cur
                                                    : 6'(cur + 6'($urandom_range(1, 63)));
      @(negedge clk);
    end
    settle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mispred_recovery_ctrl.md
Name: mispred_recovery_ctrl

Overview:
Sequences pipeline recovery after the selected branch mispredict or flush from the branch selector.
- Holds the front end stalled and the mispredict-flush signal asserted until the ROB has drained.
- Walks the rename-map restore in fixed-width chunks, then releases the pipeline.
- Sits between the branch selector output and the rename/front-end stall logic; replaces the ad-hoc flush-disable flops.

Parameters:
NUM_ARCH_REGS, 32, architectural registers restored by the rename-map walk
RESTORE_WIDTH, 4, registers restored per cycle; must divide NUM_ARCH_REGS
DRAIN_STABLE, 2, consecutive cycles curSqN==nextSqN required before restore (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
IN_branch_taken  in  1  selected branch/flush valid this cycle
IN_branch_sqN  in  6  sequence number of selected branch
IN_branch_flush  in  1  full flush; skip rename restore
IN_ROB_curSqN  in  6  ROB commit pointer
IN_RN_nextSqN  in  6  rename next sequence number
OUT_mispredFlush  out  1  suppress execution of ops younger than captured sqN
OUT_flushSqN  out  6  captured sqN
OUT_stallFE  out  1  front-end/rename stall
OUT_restoreValid  out  1  restore chunk valid
OUT_restoreIdx  out  $clog2(NUM_ARCH_REGS/RESTORE_WIDTH)  chunk index; 3 bits at defaults
OUT_busy  out  1  FSM not IDLE

Behaviour:
- Reset (rst_n low, async): state IDLE. All outputs 0; drain counter 0; chunk counter 0.
- All outputs are registered. A new branch takes effect on outputs one cycle after IN_branch_taken.
- States are IDLE, DRAIN, RESTORE, RELEASE.
- IDLE, on IN_branch_taken:
  - capture sqN and the flush bit;
  - go to DRAIN;
  - next cycle OUT_mispredFlush=1, OUT_stallFE=1, OUT_busy=1.
- Age compare uses 6-bit wrap arithmetic: a is older than b iff $signed(a-b)<0.
- IN_branch_taken while not IDLE:
  - If the new sqN is older than the captured sqN: recapture sqN and flush bit, go to DRAIN, clear drain and chunk counters. This applies from any non-IDLE state, including mid-RESTORE.
  - Otherwise (equal or younger): ignore.
- DRAIN:
  - drain counter increments while IN_ROB_curSqN==IN_RN_nextSqN and resets to 0 otherwise;
  - when the counter reaches DRAIN_STABLE-1 with equality still true, go to RESTORE, or to RELEASE if the captured flush bit is 1;
  - no timeout.
- RESTORE:
  - OUT_restoreValid=1 for NUM_ARCH_REGS/RESTORE_WIDTH consecutive cycles;
  - OUT_restoreIdx counts 0..N-1, one per cycle;
  - after index N-1, go to RELEASE.
- RELEASE (one cycle): OUT_mispredFlush=0, OUT_stallFE=0, OUT_restoreValid=0; OUT_busy still 1. Next state IDLE.
- RELEASE + IN_branch_taken in the same cycle: treated as in IDLE; go directly to DRAIN.
- OUT_flushSqN holds its last captured value when IDLE.
- IN_branch_taken in IDLE together with drain equality already true: DRAIN still takes DRAIN_STABLE cycles minimum.

Optional Feature:
MISPRED_RECOVERY_STATS_EN
- Defined:
  - adds output OUT_statMispredCnt (32 bits), which increments on every capture, including recaptures;
  - adds output OUT_statRecoveryCycles (32 bits), which increments every cycle OUT_busy=1;
  - both saturate at all-ones and reset to 0.
- Not defined: the ports and counters do not exist. Core behaviour is identical either way.

Test Plan:
- Reset: assert rst_n=0 mid-RESTORE (idx=3) with no clk edge -> all outputs 0 immediately; IDLE after release.
- Basic mispredict: taken sqN=10, flush=0; curSqN==nextSqN from cycle 2 -> mispredFlush/stallFE high from cycle 1, restoreValid cycles with idx 0..7, RELEASE, busy low.
- Full flush: taken sqN=20, flush=1, drain equal -> no restoreValid; RELEASE after 2 stable cycles.
- Older override: capture sqN=12, then mid-RESTORE taken sqN=9 -> flushSqN=9, counters cleared, restore restarts at idx 0; later sqN=15 ignored.
- Wrap-around: capture sqN=62, then taken sqN=1 -> ignored (1 is younger); capture 1 then 62 -> recapture 62.
- Drain glitch: equality true 1 cycle, false 1, then true 2 (DRAIN_STABLE=2) -> RESTORE entered only after the second consecutive true.
